// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes and
// datapath mux/ALU select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_ITEXE  = 4'd8,
    S_ITWB   = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_FAULT  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [2:0] SRCB_B        = 3'd0;
  localparam logic [2:0] SRCB_FOUR     = 3'd1;
  localparam logic [2:0] SRCB_SEXT     = 3'd2;
  localparam logic [2:0] SRCB_SEXT_SH2 = 3'd3;
  localparam logic [2:0] SRCB_ZEXT     = 3'd4;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold a memory request open until ready.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait cycles of an outstanding memory request and flags a timeout
// when the last permitted wait cycle passes without ready.
module mem_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic pending,
  input  logic ready,
  output logic timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear on request entry, on completion and when idle; count stalled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (start || !pending || ready) begin
      cnt_d = '0;
    end else if (TIMEOUT != 0) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (TIMEOUT != 0) && pending && !ready && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle controller for the MIPS-subset datapath with ready-based
// memory handshake, memory timeout and illegal-opcode fault detection.
//
// state  | meaning
// FETCH  | read instruction, PC+4 on ready
// DECODE | decode opcode, branch target into ALUOut
// MEMADR | compute load/store address
// MEMRD  | data read, wait for ready
// MEMWB  | write loaded data to register file
// MEMWR  | data write, wait for ready (retires on ready)
// RTEXE  | R-type ALU operation
// RTWB   | R-type result write-back
// ITEXE  | addi/ori ALU operation
// ITWB   | immediate result write-back
// BRANCH | compare and conditionally update PC
// JUMP   | load jump target into PC
// FAULT  | illegal opcode or memory timeout, left only by reset
module mc_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       iord_o,
  output logic       irwrite_o,
  output logic       alusrca_o,
  output logic [2:0] alusrcb_o,
  output logic [1:0] aluop_o,
  output logic [1:0] pcsource_o,
  output logic       pcen_o,
  output logic       regwrite_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic       retire_o,
  output logic       fault_o,
  output logic [3:0] state_o
);

  // TIMEOUT=0 would give a zero-width counter; one bit is kept and never counts.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t state_q;
  state_t state_d;
  logic   req_pending;
  logic   timer_start;
  logic   timeout;

  assign req_pending = is_mem_state(state_q);
  assign timer_start = is_mem_state(state_d) && (state_d != state_q);

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (timer_start),
    .pending(req_pending),
    .ready  (mem_ready_i),
    .timeout(timeout)
  );

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (timeout)          state_d = S_FAULT;
        else if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op_i)
          OP_RTYPE:        state_d = S_RTEXE;
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_ADDI, OP_ORI: state_d = S_ITEXE;
          default:         state_d = S_FAULT;
        endcase
      end
      S_MEMADR: state_d = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (timeout)          state_d = S_FAULT;
        else if (mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWB: state_d = S_FETCH;
      S_MEMWR: begin
        if (timeout)          state_d = S_FAULT;
        else if (mem_ready_i) state_d = S_FETCH;
      end
      S_RTEXE:  state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_ITEXE:  state_d = S_ITWB;
      S_ITWB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode; everything is forced low while reset is held so an
  // aborted request or write-back drops immediately.
  always_comb begin
    memread_o  = 1'b0;
    memwrite_o = 1'b0;
    iord_o     = 1'b0;
    irwrite_o  = 1'b0;
    alusrca_o  = 1'b0;
    alusrcb_o  = SRCB_B;
    aluop_o    = ALUOP_ADD;
    pcsource_o = PCSRC_ALU;
    pcen_o     = 1'b0;
    regwrite_o = 1'b0;
    regdst_o   = 1'b0;
    memtoreg_o = 1'b0;
    retire_o   = 1'b0;
    fault_o    = 1'b0;
    state_o    = 4'd0;
    if (!rst) begin
      state_o = state_q;
      case (state_q)
        S_FETCH: begin
          memread_o = 1'b1;
          alusrcb_o = SRCB_FOUR;
          irwrite_o = mem_ready_i;
          pcen_o    = mem_ready_i;
        end
        S_DECODE: alusrcb_o = SRCB_SEXT_SH2;
        S_MEMADR: begin
          alusrca_o = 1'b1;
          alusrcb_o = SRCB_SEXT;
        end
        S_MEMRD: begin
          memread_o = 1'b1;
          iord_o    = 1'b1;
        end
        S_MEMWB: begin
          regwrite_o = 1'b1;
          memtoreg_o = 1'b1;
          retire_o   = 1'b1;
        end
        S_MEMWR: begin
          memwrite_o = 1'b1;
          iord_o     = 1'b1;
          retire_o   = mem_ready_i;
        end
        S_RTEXE: begin
          alusrca_o = 1'b1;
          alusrcb_o = SRCB_B;
          aluop_o   = ALUOP_FUNCT;
        end
        S_RTWB: begin
          regwrite_o = 1'b1;
          regdst_o   = 1'b1;
          retire_o   = 1'b1;
        end
        S_ITEXE: begin
          alusrca_o = 1'b1;
          if (op_i == OP_ORI) begin
            alusrcb_o = SRCB_ZEXT;
            aluop_o   = ALUOP_OR;
          end else begin
            alusrcb_o = SRCB_SEXT;
            aluop_o   = ALUOP_ADD;
          end
        end
        S_ITWB: begin
          regwrite_o = 1'b1;
          retire_o   = 1'b1;
        end
        S_BRANCH: begin
          alusrca_o  = 1'b1;
          alusrcb_o  = SRCB_B;
          aluop_o    = ALUOP_SUB;
          pcsource_o = PCSRC_ALUOUT;
          pcen_o     = (op_i == OP_BNE) ? !zero_i : zero_i;
          retire_o   = 1'b1;
        end
        S_JUMP: begin
          pcsource_o = PCSRC_JUMP;
          pcen_o     = 1'b1;
          retire_o   = 1'b1;
        end
        S_FAULT: fault_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
`timescale 1ns/1ps
// Bench for mc_ctrl_fsm: directed instruction table, random programs against
// a latency/effect model, plus timeout, illegal-opcode and reset sequences.
module tb_mc_ctrl_fsm;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op_i;
  logic       zero_i;
  logic       mem_ready_i;

  // Output bundles: [0] memread [1] memwrite [2] iord [3] irwrite [4] alusrca
  // [7:5] alusrcb [9:8] aluop [11:10] pcsource [12] pcen [13] regwrite
  // [14] regdst [15] memtoreg [16] retire [17] fault [21:18] state
  wire [21:0] o16;
  wire [21:0] o4;
  wire [21:0] o0;

  wire       memread_o  = o16[0];
  wire       memwrite_o = o16[1];
  wire       iord_o     = o16[2];
  wire       irwrite_o  = o16[3];
  wire [2:0] alusrcb_o  = o16[7:5];
  wire [1:0] aluop_o    = o16[9:8];
  wire       pcen_o     = o16[12];
  wire       regwrite_o = o16[13];
  wire       regdst_o   = o16[14];
  wire       memtoreg_o = o16[15];
  wire       retire_o   = o16[16];
  wire       fault_o    = o16[17];
  wire [3:0] state_o    = o16[21:18];

  always #5 clk = ~clk;

  mc_ctrl_fsm u_dut (
    .clk(clk), .rst(rst), .op_i(op_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .memread_o(o16[0]), .memwrite_o(o16[1]), .iord_o(o16[2]), .irwrite_o(o16[3]),
    .alusrca_o(o16[4]), .alusrcb_o(o16[7:5]), .aluop_o(o16[9:8]), .pcsource_o(o16[11:10]),
    .pcen_o(o16[12]), .regwrite_o(o16[13]), .regdst_o(o16[14]), .memtoreg_o(o16[15]),
    .retire_o(o16[16]), .fault_o(o16[17]), .state_o(o16[21:18])
  );

  mc_ctrl_fsm #(.TIMEOUT(4)) u_dut4 (
    .clk(clk), .rst(rst), .op_i(op_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .memread_o(o4[0]), .memwrite_o(o4[1]), .iord_o(o4[2]), .irwrite_o(o4[3]),
    .alusrca_o(o4[4]), .alusrcb_o(o4[7:5]), .aluop_o(o4[9:8]), .pcsource_o(o4[11:10]),
    .pcen_o(o4[12]), .regwrite_o(o4[13]), .regdst_o(o4[14]), .memtoreg_o(o4[15]),
    .retire_o(o4[16]), .fault_o(o4[17]), .state_o(o4[21:18])
  );

  mc_ctrl_fsm #(.TIMEOUT(0)) u_dut0 (
    .clk(clk), .rst(rst), .op_i(op_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .memread_o(o0[0]), .memwrite_o(o0[1]), .iord_o(o0[2]), .irwrite_o(o0[3]),
    .alusrca_o(o0[4]), .alusrcb_o(o0[7:5]), .aluop_o(o0[9:8]), .pcsource_o(o0[11:10]),
    .pcen_o(o0[12]), .regwrite_o(o0[13]), .regdst_o(o0[14]), .memtoreg_o(o0[15]),
    .retire_o(o0[16]), .fault_o(o0[17]), .state_o(o0[21:18])
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         cycles;
    int         pcw;
    int         irw;
    int         iord;
    bit         rw;
    bit         rdst;
    bit         mtr;
    logic [7:0] srcb_mask;
    logic [3:0] aluop_mask;
    bit         fault;
    bit         hung;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    bit         z;
    int         fd;
    int         dd;
    int         exp_cycles;
    int         exp_pcw;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Effects of one instruction derived from the ISA-level rules: base
  // latency plus one cycle per wait cycle, which PC writes occur, and which
  // datapath selects are exercised along the way.
  function automatic obs_t ref_instr(input logic [5:0] op, input bit z, input int fd, input int dd);
    obs_t r;
    bit   is_mem;
    int   base;
    r = '{default: 0};
    is_mem = (op == OP_LW) || (op == OP_SW);
    case (op)
      OP_LW:          base = 5;
      OP_BEQ, OP_BNE: base = 3;
      OP_J:           base = 3;
      default:        base = 4;
    endcase
    r.cycles = base + fd + (is_mem ? dd : 0);
    r.pcw    = 1 + (((op == OP_BEQ) && z) || ((op == OP_BNE) && !z) || (op == OP_J) ? 1 : 0);
    r.irw    = 1;
    r.iord   = is_mem ? dd + 1 : 0;
    r.rw     = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_ADDI) || (op == OP_ORI);
    r.rdst   = (op == OP_RTYPE);
    r.mtr    = (op == OP_LW);
    r.srcb_mask = 8'b0000_1011;
    if (is_mem || op == OP_ADDI) r.srcb_mask[2] = 1'b1;
    if (op == OP_ORI)            r.srcb_mask[4] = 1'b1;
    r.aluop_mask = 4'b0001;
    if (op == OP_RTYPE)                   r.aluop_mask[2] = 1'b1;
    if (op == OP_ORI)                     r.aluop_mask[3] = 1'b1;
    if (op == OP_BEQ || op == OP_BNE)     r.aluop_mask[1] = 1'b1;
    return r;
  endfunction

  // Runs one instruction on the TIMEOUT=16 instance, acting as a memory that
  // answers each request after fd (fetch) or dd (data) wait cycles.
  task automatic run_instr(input logic [5:0] op, input bit z, input int fd, input int dd, output obs_t ob);
    int   acc;
    int   w;
    bit   done;
    logic req;
    acc = 0;
    w = 0;
    done = 0;
    ob = '{default: 0};
    op_i = op;
    zero_i = z;
    while (!done && ob.cycles < 200) begin
      #1;
      req = memread_o | memwrite_o;
      if (req) mem_ready_i = (w >= ((acc == 0) ? fd : dd));
      else     mem_ready_i = 1'($urandom_range(0, 1));
      #1;
      ob.cycles++;
      if (irwrite_o) ob.irw++;
      if (pcen_o)    ob.pcw++;
      if (iord_o)    ob.iord++;
      ob.srcb_mask[alusrcb_o] = 1'b1;
      ob.aluop_mask[aluop_o]  = 1'b1;
      if (fault_o) ob.fault = 1;
      if (retire_o) begin
        done = 1;
        ob.rw   = regwrite_o;
        ob.rdst = regdst_o;
        ob.mtr  = memtoreg_o;
      end
      if (req) begin
        if (mem_ready_i) begin
          acc++;
          w = 0;
        end else begin
          w++;
        end
      end
      @(negedge clk);
    end
    ob.hung = !done;
  endtask

  task automatic cmp(input string tag, input obs_t a, input obs_t e);
    check({tag, " hung"},   32'(a.hung),   32'(e.hung));
    check({tag, " cycles"}, a.cycles,      e.cycles);
    check({tag, " pcen"},   a.pcw,         e.pcw);
    check({tag, " irwr"},   a.irw,         e.irw);
    check({tag, " iord"},   a.iord,        e.iord);
    check({tag, " regwr"},  32'(a.rw),     32'(e.rw));
    check({tag, " regdst"}, 32'(a.rdst),   32'(e.rdst));
    check({tag, " mtoreg"}, 32'(a.mtr),    32'(e.mtr));
    check({tag, " srcb"},   32'(a.srcb_mask),  32'(e.srcb_mask));
    check({tag, " aluop"},  32'(a.aluop_mask), 32'(e.aluop_mask));
    check({tag, " fault"},  32'(a.fault),  32'(e.fault));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input logic rdy);
    #1;
    mem_ready_i = rdy;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[14];
    int         plan[6];
    logic [5:0] legal[8];
    obs_t       ob;
    obs_t       ex;
    int         cum;

    vecs[0]  = '{OP_ADDI,  1'b0, 0,  0,  4,  1};
    vecs[1]  = '{OP_RTYPE, 1'b0, 0,  0,  4,  1};
    vecs[2]  = '{OP_SW,    1'b0, 0,  0,  4,  1};
    vecs[3]  = '{OP_LW,    1'b0, 0,  0,  5,  1};
    vecs[4]  = '{OP_BEQ,   1'b1, 0,  0,  3,  2};
    vecs[5]  = '{OP_J,     1'b0, 0,  0,  3,  2};
    vecs[6]  = '{OP_LW,    1'b0, 3,  3,  11, 1};
    vecs[7]  = '{OP_BNE,   1'b1, 0,  0,  3,  1};
    vecs[8]  = '{OP_BNE,   1'b0, 0,  0,  3,  2};
    vecs[9]  = '{OP_BEQ,   1'b0, 1,  0,  4,  1};
    vecs[10] = '{OP_ORI,   1'b0, 2,  0,  6,  1};
    vecs[11] = '{OP_SW,    1'b0, 15, 15, 34, 1};
    vecs[12] = '{OP_LW,    1'b0, 0,  15, 20, 1};
    vecs[13] = '{OP_RTYPE, 1'b0, 15, 0,  19, 1};
    plan = '{4, 8, 12, 17, 20, 23};
    legal = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ORI};

    rst = 1'b1;
    op_i = 6'd0;
    zero_i = 1'b0;
    mem_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst outputs", 32'(o16), 32'd0);
    rst = 1'b0;
    #1;
    check("release memread", 32'(memread_o), 32'd1);
    check("release state", 32'(state_o), 32'(S_FETCH));

    cum = 0;
    for (int i = 0; i < 14; i++) begin
      run_instr(vecs[i].op, vecs[i].z, vecs[i].fd, vecs[i].dd, ob);
      ex = ref_instr(vecs[i].op, vecs[i].z, vecs[i].fd, vecs[i].dd);
      ex.cycles = vecs[i].exp_cycles;
      ex.pcw    = vecs[i].exp_pcw;
      cmp($sformatf("vec%0d", i), ob, ex);
      if (i < 6) begin
        cum += ob.cycles;
        check($sformatf("retire_at%0d", i), cum, plan[i]);
      end
    end

    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      bit         z;
      int         fd;
      int         dd;
      op = legal[$urandom_range(0, 7)];
      z  = 1'($urandom_range(0, 1));
      fd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      dd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      run_instr(op, z, fd, dd, ob);
      ex = ref_instr(op, z, fd, dd);
      cmp($sformatf("rnd%0d op%0h", i, op), ob, ex);
    end

    // Illegal opcode, then a one-cycle reset recovers.
    do_reset();
    op_i = 6'b111111;
    step(1'b1);
    @(negedge clk);
    step(1'b0);
    check("illegal decode state", 32'(state_o), 32'(S_DECODE));
    @(negedge clk);
    step(1'b0);
    check("illegal fault state", 32'(state_o), 32'(S_FAULT));
    check("illegal fault flag", 32'(fault_o), 32'd1);
    check("illegal others zero", 32'(o16[16:0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("illegal rst outputs", 32'(o16), 32'd0);
    rst = 1'b0;
    #1;
    check("recover memread", 32'(memread_o), 32'd1);
    check("recover fault", 32'(fault_o), 32'd0);
    check("recover state", 32'(state_o), 32'(S_FETCH));

    // sw whose write never completes: TIMEOUT 4 and 16 fault, 0 waits on.
    begin
      int mw4 = 0, mw16 = 0, mw0 = 0, f4_first = 0, f16_first = 0;
      int f4_cnt = 0, f4_bad = 0, f0_cnt = 0, ret4 = 0;
      do_reset();
      op_i = OP_SW;
      zero_i = 1'b0;
      for (int c = 1; c <= 120; c++) begin
        step(c == 1);
        if (o4[1])  mw4++;
        if (o16[1]) mw16++;
        if (o0[1])  mw0++;
        if (o4[17] && f4_first == 0)   f4_first = c;
        if (o16[17] && f16_first == 0) f16_first = c;
        if (o4[17]) begin
          f4_cnt++;
          if (o4[16:0] != 17'd0 || o4[21:18] != S_FAULT) f4_bad++;
        end
        if (o0[17]) f0_cnt++;
        if (o4[16]) ret4++;
        @(negedge clk);
      end
      check("to4 memwrite cycles", mw4, 4);
      check("to4 fault cycle", f4_first, 8);
      check("to4 fault held", f4_cnt, 113);
      check("to4 fault outputs", f4_bad, 0);
      check("to4 retire", ret4, 0);
      check("to16 memwrite cycles", mw16, 16);
      check("to16 fault cycle", f16_first, 20);
      check("to0 fault", f0_cnt, 0);
      check("to0 memwrite cycles", mw0, 117);
    end

    // Reset while a write is stalled: request drops, nothing retires.
    do_reset();
    op_i = OP_SW;
    step(1'b1);
    @(negedge clk);
    for (int c = 2; c <= 5; c++) begin
      step(1'b0);
      if (c < 5) @(negedge clk);
    end
    check("midrst memwrite before", 32'(memwrite_o), 32'd1);
    check("midrst state before", 32'(state_o), 32'(S_MEMWR));
    @(negedge clk);
    #1;
    rst = 1'b1;
    mem_ready_i = 1'b1;
    #1;
    check("midrst retire", 32'(retire_o), 32'd0);
    @(negedge clk);
    #1;
    check("midrst memwrite after", 32'(memwrite_o), 32'd0);
    check("midrst retire after", 32'(retire_o), 32'd0);
    rst = 1'b0;
    mem_ready_i = 1'b0;
    #1;
    check("midrst fetch", 32'(state_o), 32'(S_FETCH));
    check("midrst memread", 32'(memread_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
